// File: rtl/deck_dealer_pkg.sv
// rtl/deck_dealer_pkg.sv - shared deck constants, dealer states and shuffle helper
// Contents: deck size, card rank/value constants, LFSR tap mask, FSM state type,
//           and swap_mask() giving the smallest all-ones mask covering 0..i.
package deck_dealer_pkg;

  localparam int          DECK_SIZE  = 52;
  localparam logic [5:0]  LAST_IDX   = 6'd51;
  localparam logic [5:0]  FULL_DECK  = 6'd52;

  localparam logic [3:0]  RANK_ACE   = 4'd1;
  localparam logic [3:0]  RANK_JACK  = 4'd11;
  localparam logic [3:0]  RANK_QUEEN = 4'd12;
  localparam logic [3:0]  RANK_KING  = 4'd13;
  localparam logic [3:0]  FACE_VALUE = 4'd10;

  // Galois form of x^16+x^14+x^13+x^11+1 (right-shifting)
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_SHUFFLE = 2'd2,
    ST_READY   = 2'd3
  } state_e;

  // (next power of two >= i+1) - 1; keeps random draws close to the valid range 0..i
  function automatic logic [5:0] swap_mask(input logic [5:0] i);
    if (i >= 6'd32)      return 6'd63;
    else if (i >= 6'd16) return 6'd31;
    else if (i >= 6'd8)  return 6'd15;
    else if (i >= 6'd4)  return 6'd7;
    else if (i >= 6'd2)  return 6'd3;
    else                 return 6'd1;
  endfunction

endpackage

// File: rtl/deck_dealer_lfsr16.sv
// rtl/deck_dealer_lfsr16.sv - free-running 16-bit Galois LFSR
// Ports: clk  - clock, rising edge
//        rst  - asynchronous active-low reset, loads SEED
//        q    - current LFSR state, advances every cycle out of reset
module lfsr16
  import deck_dealer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/deck_dealer.sv
// rtl/deck_dealer.sv - 52-card deck owner: rebuild, Fisher-Yates shuffle, one card per deal
// Ports: clk, rst (async active-low)
//        shuffle_req, deal_req          - 1-cycle request pulses
//        busy, ready, deck_empty        - state flags (busy: INIT/SHUFFLE, ready: READY)
//        cards_left[5:0]                - undealt cards 0..52
//        card_valid                     - 1-cycle pulse, card_* updated this cycle
//        card_id/suit/rank/value        - registered, held between deals
//        deal_err                       - 1-cycle pulse: deal with empty deck
module deck_dealer
  import deck_dealer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter bit          SHUFFLE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_req,
  input  logic       deal_req,
  output logic       busy,
  output logic       ready,
  output logic       deck_empty,
  output logic [5:0] cards_left,
  output logic       card_valid,
  output logic [5:0] card_id,
  output logic [1:0] card_suit,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic       deal_err
);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] ptr_q, ptr_d;
  logic [5:0] cards_left_q, cards_left_d;
  logic       card_valid_q, card_valid_d;
  logic       deal_err_q, deal_err_d;
  logic [5:0] card_id_q, card_id_d;
  logic [1:0] card_suit_q, card_suit_d;
  logic [3:0] card_rank_q, card_rank_d;
  logic [3:0] card_value_q, card_value_d;

  // Deck storage has no reset: contents are rebuilt by INIT before any deal
  logic [5:0] deck_q [DECK_SIZE];
  logic [5:0] deck_d [DECK_SIZE];

  logic [15:0] lfsr_q;
  logic        unused_lfsr;
  logic [5:0]  r_idx;

  logic [5:0] cur_id;
  logic [1:0] cur_suit;
  logic [3:0] cur_rem;
  logic [3:0] cur_rank;
  logic [3:0] cur_value;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:6];
  assign r_idx       = lfsr_q[5:0] & swap_mask(idx_q);

  // Suit/rank by compare-subtract; only ids 0..51 are ever stored
  assign cur_id = deck_q[ptr_q];

  always_comb begin
    cur_suit = 2'd0;
    cur_rem  = cur_id[3:0];
    if (cur_id >= 6'd39) begin
      cur_suit = 2'd3;
      cur_rem  = 4'(cur_id - 6'd39);
    end else if (cur_id >= 6'd26) begin
      cur_suit = 2'd2;
      cur_rem  = 4'(cur_id - 6'd26);
    end else if (cur_id >= 6'd13) begin
      cur_suit = 2'd1;
      cur_rem  = 4'(cur_id - 6'd13);
    end
    cur_rank  = cur_rem + RANK_ACE;
    cur_value = (cur_rank >= RANK_JACK) ? FACE_VALUE : cur_rank;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cards_left_d = cards_left_q;
    card_valid_d = 1'b0;
    deal_err_d   = 1'b0;
    card_id_d    = card_id_q;
    card_suit_d  = card_suit_q;
    card_rank_d  = card_rank_q;
    card_value_d = card_value_q;
    deck_d       = deck_q;

    // A shuffle request from any state restarts the rebuild and drops a same-cycle deal
    if (shuffle_req) begin
      state_d      = ST_INIT;
      idx_d        = 6'd0;
      ptr_d        = 6'd0;
      cards_left_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_INIT: begin
          deck_d[idx_q] = idx_q;
          if (idx_q == LAST_IDX) begin
            if (SHUFFLE_EN) begin
              state_d = ST_SHUFFLE;
              idx_d   = LAST_IDX;
            end else begin
              state_d      = ST_READY;
              ptr_d        = 6'd0;
              cards_left_d = FULL_DECK;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_SHUFFLE: begin
          // Out-of-range draws are rejected and retried with the next LFSR value
          if (r_idx <= idx_q) begin
            deck_d[idx_q] = deck_q[r_idx];
            deck_d[r_idx] = deck_q[idx_q];
            if (idx_q == 6'd1) begin
              state_d      = ST_READY;
              ptr_d        = 6'd0;
              cards_left_d = FULL_DECK;
            end else begin
              idx_d = idx_q - 6'd1;
            end
          end
        end
        ST_READY: begin
          if (deal_req) begin
            if (cards_left_q != 6'd0) begin
              card_valid_d = 1'b1;
              card_id_d    = cur_id;
              card_suit_d  = cur_suit;
              card_rank_d  = cur_rank;
              card_value_d = cur_value;
              ptr_d        = ptr_q + 6'd1;
              cards_left_d = cards_left_q - 6'd1;
            end else begin
              deal_err_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      ptr_q        <= 6'd0;
      cards_left_q <= 6'd0;
      card_valid_q <= 1'b0;
      deal_err_q   <= 1'b0;
      card_id_q    <= 6'd0;
      card_suit_q  <= 2'd0;
      card_rank_q  <= 4'd0;
      card_value_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      cards_left_q <= cards_left_d;
      card_valid_q <= card_valid_d;
      deal_err_q   <= deal_err_d;
      card_id_q    <= card_id_d;
      card_suit_q  <= card_suit_d;
      card_rank_q  <= card_rank_d;
      card_value_q <= card_value_d;
    end
  end

  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign busy       = (state_q == ST_INIT) || (state_q == ST_SHUFFLE);
  assign ready      = (state_q == ST_READY);
  assign deck_empty = (state_q == ST_READY) && (cards_left_q == 6'd0);
  assign cards_left = cards_left_q;
  assign card_valid = card_valid_q;
  assign card_id    = card_id_q;
  assign card_suit  = card_suit_q;
  assign card_rank  = card_rank_q;
  assign card_value = card_value_q;
  assign deal_err   = deal_err_q;

endmodule
